// File: rtl/packet_tuple_pipe.sv
// Header-beat parser: extracts the IPv4 5-tuple from one wide header beat
// through a two-stage valid/ready pipeline, with accept/drop statistics.
module packet_tuple_pipe #(
  parameter int DATA_W      = 512,
  parameter int VLAN_EN     = 1,
  parameter int DROP_NON_IP = 0,
  parameter int CNT_W       = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              rx_valid,
  input  logic [DATA_W-1:0] rx_data,
  output logic              rx_ready,
  output logic              tx_valid,
  output logic [103:0]      tx_data,
  output logic [2:0]        tx_flags,
  input  logic              tx_ready,
  output logic [CNT_W-1:0]  rx_pkt_cnt,
  output logic [CNT_W-1:0]  drop_cnt
);

  // Handshake: a beat moves on a channel only in a cycle where valid and ready
  // are both 1; a producer holds valid and data steady until that cycle.

  localparam int OFF_U = 14;
  localparam int OFF_V = 18;

  function automatic logic [15:0] be16(input logic [15:0] le);
    return {le[7:0], le[15:8]};
  endfunction

  function automatic logic [31:0] be32(input logic [31:0] le);
    return {le[7:0], le[15:8], le[23:16], le[31:24]};
  endfunction

  // t holds L3 bytes 12..23 in wire order: src_ip, dst_ip, src_port, dst_port.
  function automatic logic [111:0] pick(input logic [7:0] vi, input logic [7:0] pr,
                                        input logic [95:0] t);
    return {vi, pr, be32(t[31:0]), be32(t[63:32]), be16(t[79:64]), be16(t[95:80])};
  endfunction

  logic [15:0]  tag_w;
  logic [15:0]  etype_w;
  logic         vlan_w;
  logic [111:0] fld_w;
  logic         unused_rx;

  assign tag_w   = be16(rx_data[8*12 +: 16]);
  assign vlan_w  = (VLAN_EN != 0) && (tag_w == 16'h8100);
  assign etype_w = vlan_w ? be16(rx_data[8*(OFF_V-2) +: 16]) : tag_w;
  assign fld_w   = vlan_w
    ? pick(rx_data[8*OFF_V +: 8], rx_data[8*(OFF_V+9) +: 8], rx_data[8*(OFF_V+12) +: 96])
    : pick(rx_data[8*OFF_U +: 8], rx_data[8*(OFF_U+9) +: 8], rx_data[8*(OFF_U+12) +: 96]);
  assign unused_rx = ^rx_data;

  logic         s1_valid_q, s1_valid_d;
  logic         s1_vlan_q,  s1_vlan_d;
  logic         s1_eip_q,   s1_eip_d;
  logic [111:0] s1_fld_q,   s1_fld_d;
  logic         tx_valid_q, tx_valid_d;
  logic [103:0] tx_data_q,  tx_data_d;
  logic [2:0]   tx_flags_q, tx_flags_d;
  logic [CNT_W-1:0] rx_cnt_q, rx_cnt_d;
  logic [CNT_W-1:0] drop_cnt_q, drop_cnt_d;

  // S2 decode of the registered L3 fields.
  logic [7:0]  s2_vi, s2_pr;
  logic [31:0] s2_sip, s2_dip;
  logic [15:0] s2_sp, s2_dp;
  logic        s2_ipv4, s2_l4;

  assign {s2_vi, s2_pr, s2_sip, s2_dip, s2_sp, s2_dp} = s1_fld_q;
  assign s2_ipv4 = s1_eip_q && (s2_vi[7:4] == 4'h4);
  assign s2_l4   = s2_ipv4 && (s2_vi[3:0] == 4'h5) && (s2_pr == 8'd6 || s2_pr == 8'd17);

  logic s2_free, s1_adv, rx_fire, drop;

  assign s2_free  = !tx_valid_q || tx_ready;
  assign s1_adv   = s1_valid_q && s2_free;
  assign rx_ready = !s1_valid_q || s1_adv;
  assign rx_fire  = rx_valid && rx_ready;
  assign drop     = s1_adv && (DROP_NON_IP != 0) && !s2_ipv4;

  always_comb begin
    s1_valid_d = s1_valid_q;
    s1_vlan_d  = s1_vlan_q;
    s1_eip_d   = s1_eip_q;
    s1_fld_d   = s1_fld_q;
    tx_valid_d = tx_valid_q;
    tx_data_d  = tx_data_q;
    tx_flags_d = tx_flags_q;
    rx_cnt_d   = rx_cnt_q + CNT_W'(rx_fire);
    drop_cnt_d = drop_cnt_q + CNT_W'(drop);
    if (rx_ready) s1_valid_d = rx_valid;
    if (rx_fire) begin
      s1_vlan_d = vlan_w;
      s1_eip_d  = (etype_w == 16'h0800);
      s1_fld_d  = fld_w;
    end
    // A dropped beat leaves S2 untouched; S2 empties if its tuple was taken.
    if (s2_free) tx_valid_d = s1_valid_q && !drop;
    if (s1_adv && !drop) begin
      tx_flags_d = {s1_vlan_q, s2_ipv4, s2_l4};
      tx_data_d  = s2_ipv4 ? {s2_sip, s2_dip, s2_l4 ? s2_sp : 16'h0,
                              s2_l4 ? s2_dp : 16'h0, s2_pr} : 104'h0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q <= 1'b0;
      s1_vlan_q  <= 1'b0;
      s1_eip_q   <= 1'b0;
      s1_fld_q   <= '0;
      tx_valid_q <= 1'b0;
      tx_data_q  <= '0;
      tx_flags_q <= '0;
      rx_cnt_q   <= '0;
      drop_cnt_q <= '0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_vlan_q  <= s1_vlan_d;
      s1_eip_q   <= s1_eip_d;
      s1_fld_q   <= s1_fld_d;
      tx_valid_q <= tx_valid_d;
      tx_data_q  <= tx_data_d;
      tx_flags_q <= tx_flags_d;
      rx_cnt_q   <= rx_cnt_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

  assign tx_valid   = tx_valid_q;
  assign tx_data    = tx_data_q;
  assign tx_flags   = tx_flags_q;
  assign rx_pkt_cnt = rx_cnt_q;
  assign drop_cnt   = drop_cnt_q;

endmodule

// File: tb/tb_packet_tuple_pipe.sv
// Bench for packet_tuple_pipe: a forwarding instance and a DROP_NON_IP
// instance share the rx stimulus; tuples are predicted from packet descriptors.
module tb_packet_tuple_pipe;
  localparam int DW = 512;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          rx_valid = 1'b0;
  logic [DW-1:0] rx_data = '0;
  logic          tx_ready = 1'b0;
  logic          rx_ready, tx_valid;
  logic [103:0]  tx_data;
  logic [2:0]    tx_flags;
  logic [31:0]   rx_pkt_cnt, drop_cnt;
  logic          d_rx_ready, d_tx_valid;
  logic [103:0]  d_tx_data;
  logic [2:0]    d_tx_flags;
  logic [31:0]   d_rx_pkt_cnt, d_drop_cnt;

  packet_tuple_pipe #(.DATA_W(DW), .VLAN_EN(1), .DROP_NON_IP(0), .CNT_W(32)) u_dut (
    .clk(clk), .rst_n(rst_n), .rx_valid(rx_valid), .rx_data(rx_data), .rx_ready(rx_ready),
    .tx_valid(tx_valid), .tx_data(tx_data), .tx_flags(tx_flags), .tx_ready(tx_ready),
    .rx_pkt_cnt(rx_pkt_cnt), .drop_cnt(drop_cnt));

  packet_tuple_pipe #(.DATA_W(DW), .VLAN_EN(1), .DROP_NON_IP(1), .CNT_W(32)) u_drop (
    .clk(clk), .rst_n(rst_n), .rx_valid(rx_valid), .rx_data(rx_data), .rx_ready(d_rx_ready),
    .tx_valid(d_tx_valid), .tx_data(d_tx_data), .tx_flags(d_tx_flags), .tx_ready(1'b1),
    .rx_pkt_cnt(d_rx_pkt_cnt), .drop_cnt(d_drop_cnt));

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- packet model ----------------
  typedef struct packed {
    logic        vlan;
    logic [15:0] etype;
    logic [3:0]  ver;
    logic [3:0]  ihl;
    logic [7:0]  proto;
    logic [31:0] sip;
    logic [31:0] dip;
    logic [15:0] sp;
    logic [15:0] dp;
  } pkt_t;

  pkt_t cur_pkt;
  int checks = 0;
  int failures = 0;
  logic [106:0] exp_q[$];
  logic [106:0] d_exp_q[$];
  int unsigned exp_rx = 0, d_exp_rx = 0, d_exp_drop = 0;

  function automatic logic [DW-1:0] build(pkt_t p);
    logic [7:0] b[64];
    int l3;
    logic [DW-1:0] v;
    for (int i = 0; i < 64; i++) b[i] = 8'($urandom);
    l3 = p.vlan ? 18 : 14;
    if (p.vlan) {b[12], b[13]} = 16'h8100;
    {b[l3-2], b[l3-1]} = p.etype;
    b[l3] = {p.ver, p.ihl};
    b[l3+9] = p.proto;
    {b[l3+12], b[l3+13], b[l3+14], b[l3+15]} = p.sip;
    {b[l3+16], b[l3+17], b[l3+18], b[l3+19]} = p.dip;
    {b[l3+20], b[l3+21]} = p.sp;
    {b[l3+22], b[l3+23]} = p.dp;
    for (int k = 0; k < 64; k++) v[8*k +: 8] = b[k];
    return v;
  endfunction

  // Expected {tx_data, tx_flags} straight from the descriptor.
  function automatic logic [106:0] expect_of(pkt_t p);
    logic ip, l4;
    logic [103:0] d;
    ip = (p.etype == 16'h0800) && (p.ver == 4'd4);
    l4 = ip && (p.ihl == 4'd5) && (p.proto == 8'd6 || p.proto == 8'd17);
    d  = ip ? {p.sip, p.dip, l4 ? p.sp : 16'h0, l4 ? p.dp : 16'h0, p.proto} : 104'h0;
    return {d, p.vlan, ip, l4};
  endfunction

  function automatic pkt_t rand_pkt();
    pkt_t p;
    p.vlan  = 1'($urandom_range(0, 1));
    case ($urandom_range(0, 5))
      0: p.etype = 16'h0806;
      1: p.etype = 16'h86DD;
      default: p.etype = 16'h0800;
    endcase
    p.ver = ($urandom_range(0, 7) == 0) ? 4'd6 : 4'd4;
    p.ihl = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(6, 15)) : 4'd5;
    case ($urandom_range(0, 3))
      0: p.proto = 8'd6;
      1: p.proto = 8'd17;
      2: p.proto = 8'd1;
      default: p.proto = 8'($urandom);
    endcase
    p.sip = $urandom; p.dip = $urandom;
    p.sp = 16'($urandom); p.dp = 16'($urandom);
    return p;
  endfunction

  function automatic pkt_t mk(logic vlan, logic [15:0] et, logic [3:0] ihl, logic [7:0] pr,
                              logic [31:0] sip, logic [31:0] dip, logic [15:0] sp, logic [15:0] dp);
    pkt_t p;
    p = '{vlan: vlan, etype: et, ver: 4'd4, ihl: ihl, proto: pr, sip: sip, dip: dip, sp: sp, dp: dp};
    return p;
  endfunction

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // ---------------- scoreboard ----------------
  logic         stalled = 1'b0;
  logic [106:0] held;

  always @(negedge clk) begin
    if (!rst_n) begin
      exp_q.delete(); d_exp_q.delete();
      exp_rx = 0; d_exp_rx = 0; d_exp_drop = 0;
      stalled = 1'b0;
    end else begin
      if (stalled) chk("tx_stable", {tx_valid, tx_data, tx_flags}, {1'b1, held});
      stalled = tx_valid && !tx_ready;
      held = {tx_data, tx_flags};
      if (tx_valid && tx_ready) begin
        if (exp_q.size() == 0) chk("tx_unexpected_valid", tx_valid, 0);
        else chk("tx_tuple", {tx_data, tx_flags}, exp_q.pop_front());
      end
      if (d_tx_valid) begin
        if (d_exp_q.size() == 0) chk("drop_tx_unexpected_valid", d_tx_valid, 0);
        else chk("drop_tx_tuple", {d_tx_data, d_tx_flags}, d_exp_q.pop_front());
      end
      if (rx_valid && rx_ready) begin
        exp_q.push_back(expect_of(cur_pkt));
        exp_rx++;
      end
      if (rx_valid && d_rx_ready) begin
        logic [106:0] e;
        e = expect_of(cur_pkt);
        d_exp_rx++;
        if (e[1]) d_exp_q.push_back(e);
        else d_exp_drop++;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk); #1;
  endtask

  // Presents one beat and returns 1 time unit after the edge that accepted it.
  task automatic send(input pkt_t p);
    int n;
    n = 0;
    cur_pkt  = p;
    rx_data  = build(p);
    rx_valid = 1'b1;
    forever begin
      @(negedge clk);
      if (rx_ready) break;
      n++;
      if (n > 50) begin
        chk("rx_accept_timeout", rx_ready, 1);
        break;
      end
    end
    @(posedge clk); #1;
    rx_valid = 1'b0;
  endtask

  task automatic directed(input string tag, input pkt_t p, input logic [103:0] ed,
                          input logic [2:0] ef, input logic edv);
    tx_ready = 1'b1;
    send(p);
    chk({tag, "_lat1_valid"}, tx_valid, 0);
    step();
    chk({tag, "_lat2_valid"}, tx_valid, 1);
    chk({tag, "_data"}, tx_data, ed);
    chk({tag, "_flags"}, tx_flags, ef);
    chk({tag, "_drop_inst_valid"}, d_tx_valid, edv);
    step(); step();
  endtask

  task automatic async_reset(input string tag);
    #3 rst_n = 1'b0;
    #1;
    chk({tag, "_tx_valid"}, tx_valid, 0);
    chk({tag, "_tx_data"}, tx_data, 0);
    chk({tag, "_tx_flags"}, tx_flags, 0);
    chk({tag, "_rx_cnt"}, rx_pkt_cnt, 0);
    chk({tag, "_drop_cnt"}, drop_cnt, 0);
    chk({tag, "_d_rx_cnt"}, d_rx_pkt_cnt, 0);
    step(); step();
    rst_n = 1'b1;
    step();
    chk({tag, "_rx_ready"}, rx_ready, 1);
  endtask

  // ---------------- directed + random sequence ----------------
  initial begin
    pkt_t beats[8];
    logic [DW-1:0] bdata[8];
    int idx, cyc, sent;
    logic acc;

    #2;
    chk("rst_tx_valid", tx_valid, 0);
    chk("rst_tx_data", tx_data, 0);
    chk("rst_tx_flags", tx_flags, 0);
    chk("rst_rx_cnt", rx_pkt_cnt, 0);
    chk("rst_drop_cnt", d_drop_cnt, 0);
    step(); step();
    rst_n = 1'b1;
    step();
    chk("rst_rx_ready", rx_ready, 1);

    directed("tcp", mk(0, 16'h0800, 4'd5, 8'd6, 32'h0A000001, 32'h0A000002, 16'd1234, 16'd80),
             104'h0A000001_0A000002_04D2_0050_06, 3'b011, 1'b1);
    directed("vlan_udp", mk(1, 16'h0800, 4'd5, 8'd17, 32'hC0A80001, 32'h08080808, 16'd53, 16'd5353),
             104'hC0A80001_08080808_0035_14E9_11, 3'b111, 1'b1);
    directed("ihl6", mk(0, 16'h0800, 4'd6, 8'd6, 32'hAC100001, 32'hAC100002, 16'h1111, 16'h2222),
             104'hAC100001_AC100002_0000_0000_06, 3'b010, 1'b1);
    directed("arp", mk(0, 16'h0806, 4'd5, 8'd6, 32'h01020304, 32'h05060708, 16'h1, 16'h2),
             104'h0, 3'b000, 1'b0);
    step(); step();
    chk("cnt_rx_after_directed", rx_pkt_cnt, 4);
    chk("cnt_drop_after_directed", drop_cnt, 0);
    chk("drop_inst_rx_cnt", d_rx_pkt_cnt, 4);
    chk("drop_inst_drop_cnt", d_drop_cnt, 1);

    // Eight back-to-back beats against a 5-cycle stall.
    async_reset("rst_mid");
    for (int i = 0; i < 8; i++) begin
      beats[i] = rand_pkt();
      beats[i].etype = 16'h0800;
      beats[i].ver = 4'd4;
      bdata[i] = build(beats[i]);
    end
    idx = 0; cyc = 0;
    while ((idx < 8 || exp_q.size() != 0) && cyc < 100) begin
      tx_ready = (cyc >= 5);
      rx_valid = (idx < 8);
      if (idx < 8) begin
        cur_pkt = beats[idx];
        rx_data = bdata[idx];
      end
      @(negedge clk);
      if (cyc >= 2 && cyc < 5) begin
        chk("stall_rx_ready", rx_ready, 0);
        chk("stall_rx_cnt", rx_pkt_cnt, 2);
        chk("stall_tx_head", {tx_valid, tx_data, tx_flags}, {1'b1, expect_of(beats[0])});
      end
      if (rx_valid && rx_ready) idx++;
      @(posedge clk); #1;
      cyc++;
    end
    rx_valid = 1'b0;
    chk("stall_all_out", exp_q.size(), 0);
    chk("stall_rx_cnt_total", rx_pkt_cnt, 8);

    // Reset with two beats in flight must leave nothing behind.
    tx_ready = 1'b0;
    send(rand_pkt());
    send(rand_pkt());
    async_reset("rst_inflight");
    tx_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("post_reset_no_tx", tx_valid, 0);
      @(posedge clk); #1;
    end

    // Randomized traffic with random backpressure.
    sent = 0; cyc = 0;
    while (sent < 60 && cyc < 2000) begin
      tx_ready = ($urandom_range(0, 3) != 0);
      if (!rx_valid && $urandom_range(0, 3) != 0) begin
        cur_pkt  = rand_pkt();
        rx_data  = build(cur_pkt);
        rx_valid = 1'b1;
      end
      @(negedge clk);
      acc = rx_valid && rx_ready;
      @(posedge clk); #1;
      cyc++;
      if (acc) begin
        rx_valid = 1'b0;
        sent++;
      end
    end
    rx_valid = 1'b0;
    tx_ready = 1'b1;
    for (int i = 0; i < 6; i++) step();
    chk("rand_sent", sent, 60);
    chk("rand_main_drained", exp_q.size(), 0);
    chk("rand_drop_drained", d_exp_q.size(), 0);
    chk("rand_rx_cnt", rx_pkt_cnt, exp_rx);
    chk("rand_drop_cnt_main", drop_cnt, 0);
    chk("rand_d_rx_cnt", d_rx_pkt_cnt, d_exp_rx);
    chk("rand_d_drop_cnt", d_drop_cnt, d_exp_drop);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/packet_tuple_pipe.md
PACKET_TUPLE_PIPE -- requirements
Module: packet_tuple_pipe

Interface
REQ-001 Parameter DATA_W, default 512: rx_data width in bits; SHALL be a multiple of 8 and >= 336.
REQ-002 Parameter VLAN_EN, default 1: 1 enables parsing of a single 802.1Q tag.
REQ-003 Parameter DROP_NON_IP, default 0: 1 discards non-IPv4 beats; 0 forwards them with zero tuple.
REQ-004 Parameter CNT_W, default 32: width of statistics counters.
REQ-005 clk  input  1  sole clock; all logic on rising edge.
REQ-006 rst_n  input  1  reset, asynchronous and active-low.
REQ-007 rx_valid  input  1  header beat valid.
REQ-008 rx_data  input  DATA_W  header beat; byte k at bits [8k+7:8k]; byte 0 is the first wire byte.
REQ-009 rx_ready  output  1  block accepts rx_data this cycle.
REQ-010 tx_valid  output  1  tuple valid.
REQ-011 tx_data  output  104  {src_ip[31:0], dst_ip[31:0], src_port[15:0], dst_port[15:0], protocol[7:0]}, MSB first.
REQ-012 tx_flags  output  3  {is_vlan, is_ipv4, l4_ok}.
REQ-013 tx_ready  input  1  downstream accepts tx_data.
REQ-014 rx_pkt_cnt  output  CNT_W  count of accepted beats.
REQ-015 drop_cnt  output  CNT_W  count of discarded beats.

Function
REQ-016 A transfer SHALL occur on a channel only in a cycle where valid and ready are both 1.
REQ-017 Multi-byte fields SHALL be big-endian: a field at bytes n..n+m maps byte n to its MSB.
REQ-018 L3 offset SHALL be 18 when VLAN_EN=1 and bytes 12-13 equal 0x8100, otherwise 14; is_vlan SHALL be set when offset is 18.
REQ-019 Ethertype SHALL be read at L3offset-2; is_ipv4 SHALL be 1 iff ethertype is 0x0800 and the upper nibble of byte L3 is 4.
REQ-020 For is_ipv4=1: protocol = byte L3+9, src_ip = bytes L3+12..15, dst_ip = bytes L3+16..19.
REQ-021 l4_ok SHALL be 1 iff is_ipv4=1, IHL (low nibble of byte L3) equals 5, and protocol is 6 or 17; then src_port = bytes L3+20..21 and dst_port = bytes L3+22..23.
REQ-022 When l4_ok=0, src_port and dst_port SHALL be 0; when is_ipv4=0, all of tx_data SHALL be 0.
REQ-023 The datapath SHALL be a two-stage pipeline: S1 registers offset and ethertype decode, and S2 registers tx_data and tx_flags.
REQ-024 Latency SHALL be exactly 2 cycles from rx accept to tx_valid=1 when the pipeline is empty and tx_ready=1.
REQ-025 Throughput SHALL be one beat per cycle while tx_ready=1.
REQ-026 Each stage SHALL load when it is empty or when its contents advance in the same cycle; rx_ready SHALL equal !s1_valid | s1_advance.
REQ-027 tx_valid, tx_data and tx_flags SHALL remain stable while tx_valid=1 and tx_ready=0.
REQ-028 With tx_ready=0, at most 2 beats SHALL be held; the third rx_valid SHALL see rx_ready=0.
REQ-029 With DROP_NON_IP=1, a beat with is_ipv4=0 SHALL be consumed at S1->S2 without setting S2 valid, and SHALL increment drop_cnt by 1.
REQ-030 rx_pkt_cnt SHALL increment by 1 on every rx transfer, including dropped beats.
REQ-031 Both counters SHALL wrap modulo 2^CNT_W.
REQ-032 A drop and a new accept in the same cycle SHALL update both counters.
REQ-033 No combinational path SHALL exist from rx_valid or rx_data to tx_*, or from tx_ready to tx_*.

Reset
REQ-034 When rst_n=0, the block SHALL immediately clear s1_valid, tx_valid, tx_data, tx_flags, rx_pkt_cnt and drop_cnt to 0, without waiting for clk.
REQ-035 rx_ready SHALL be 1 from the first clk edge after rst_n deasserts.
REQ-036 A reset asserted mid-operation SHALL discard all in-flight beats, with no tx transfer for them after reset.

Verification
REQ-037 Untagged IPv4/TCP beat (10.0.0.1:1234 -> 10.0.0.2:80, IHL 5) with tx_ready=1 -> 2 cycles later tx_data = 0x0A000001_0A000002_04D2_0050_06 and tx_flags = 3'b011.
REQ-038 VLAN-tagged IPv4/UDP beat (proto 17, ports 53->5353), VLAN_EN=1 -> tx_flags = 3'b111 and ports 0x0035/0x14E9.
REQ-039 IPv4 beat with IHL=6 and proto 6 -> IPs correct, ports 0, tx_flags = 3'b010.
REQ-040 ARP beat (0x0806): with DROP_NON_IP=0 -> tx_data 0, tx_flags 0; with DROP_NON_IP=1 -> no tx_valid, drop_cnt=1, rx_pkt_cnt=1.
REQ-041 Continuous 8 beats with tx_ready held 0 for 5 cycles -> rx_ready=0 after 2 beats are held, tx_data stable while stalled, all 8 tuples out in order once tx_ready=1, rx_pkt_cnt=8.
REQ-042 rst_n pulsed low with 2 beats in flight -> tx_valid and counters are 0 immediately, and no stale tuple appears after release.
